// File: rtl/packet_arbiter_if.sv
// -----------------------------------------------------------------------------
// packet_arbiter_if
// Groups the BFT-facing stream and the requester handshakes of packet_arbiter.
//   i_bft_ready   BFT accepted the packet currently on o_stream
//   i_fs_req      freespace request per input port (level)
//   i_fs_packet   freespace packet per input port, packed port-major
//   o_fs_grant    one-hot, 1-cycle pulse: freespace packet taken
//   i_empty       output FIFO empty flags
//   i_out_packet  FWFT FIFO head data, packed port-major
//   o_rd_en       one-hot, 1-cycle FIFO pop pulse
//   o_stream      packet presented to the BFT (zero when idle)
//   o_busy        a packet is held on o_stream
// Modport master is the arbiter side, slave is the surrounding logic.
// -----------------------------------------------------------------------------
interface packet_arbiter_if #(
   parameter int PACKET_BITS   = 97,
   parameter int NUM_IN_PORTS  = 7,
   parameter int NUM_OUT_PORTS = 7
);
   logic                                   i_bft_ready;
   logic [NUM_IN_PORTS-1:0]                i_fs_req;
   logic [PACKET_BITS*NUM_IN_PORTS-1:0]    i_fs_packet;
   logic [NUM_IN_PORTS-1:0]                o_fs_grant;
   logic [NUM_OUT_PORTS-1:0]               i_empty;
   logic [PACKET_BITS*NUM_OUT_PORTS-1:0]   i_out_packet;
   logic [NUM_OUT_PORTS-1:0]               o_rd_en;
   logic [PACKET_BITS-1:0]                 o_stream;
   logic                                   o_busy;

   modport master (
      input  i_bft_ready, i_fs_req, i_fs_packet, i_empty, i_out_packet,
      output o_fs_grant, o_rd_en, o_stream, o_busy
   );

   modport slave (
      output i_bft_ready, i_fs_req, i_fs_packet, i_empty, i_out_packet,
      input  o_fs_grant, o_rd_en, o_stream, o_busy
   );
endinterface

// File: rtl/packet_arbiter.sv
// -----------------------------------------------------------------------------
// packet_arbiter
// Schedules the single BFT-facing stream between freespace-update packets
// (from the input ports) and data packets (from the output-port FIFOs).
// Round-robin inside each class; freespace has priority but may only take
// MAX_FS_BURST consecutive slots while any FIFO holds data.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   bus          packet_arbiter_if.master (stream + requester handshakes)
// Optional build macro PACKET_ARBITER_STATS_EN adds:
//   o_fs_count    freespace grants (wraps at 2^32)
//   o_data_count  data grants (wraps at 2^32)
//   o_stall_count HOLD cycles with i_bft_ready low
// -----------------------------------------------------------------------------
module packet_arbiter #(
   parameter int PACKET_BITS   = 97,
   parameter int NUM_IN_PORTS  = 7,
   parameter int NUM_OUT_PORTS = 7,
   parameter int MAX_FS_BURST  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   packet_arbiter_if.master     bus
`ifdef PACKET_ARBITER_STATS_EN
   ,
   output logic [31:0]          o_fs_count,
   output logic [31:0]          o_data_count,
   output logic [31:0]          o_stall_count
`endif
);

   localparam int FS_PW    = (NUM_IN_PORTS  > 1) ? $clog2(NUM_IN_PORTS)  : 1;
   localparam int OUT_PW   = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int BURST_W  = $clog2(MAX_FS_BURST + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   state_e                     state_q,    state_d;
   logic [FS_PW-1:0]           fs_ptr_q,   fs_ptr_d;
   logic [OUT_PW-1:0]          out_ptr_q,  out_ptr_d;
   logic [BURST_W-1:0]         burst_q,    burst_d;
   logic [PACKET_BITS-1:0]     stream_q,   stream_d;
   logic [NUM_IN_PORTS-1:0]    fs_grant_q, fs_grant_d;
   logic [NUM_OUT_PORTS-1:0]   rd_en_q,    rd_en_d;
   logic                       busy_q,     busy_d;

   logic                       load_slot_s;
   logic                       all_empty_s;
   logic                       fs_sel_s;
   logic                       data_sel_s;
   logic [FS_PW-1:0]           fs_win_s;
   logic [OUT_PW-1:0]          out_win_s;

   // First set bit of req at or after ptr, wrapping past the top port.
   function automatic logic [FS_PW-1:0] fs_rr_pick(input logic [NUM_IN_PORTS-1:0] req,
                                                   input logic [FS_PW-1:0]        ptr);
      logic [FS_PW-1:0] win;
      logic             found;
      int               idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_IN_PORTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_IN_PORTS) idx = idx - NUM_IN_PORTS;
         if (!found && req[idx]) begin
            win   = FS_PW'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [OUT_PW-1:0] out_rr_pick(input logic [NUM_OUT_PORTS-1:0] req,
                                                     input logic [OUT_PW-1:0]        ptr);
      logic [OUT_PW-1:0] win;
      logic              found;
      int                idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_OUT_PORTS) idx = idx - NUM_OUT_PORTS;
         if (!found && req[idx]) begin
            win   = OUT_PW'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [FS_PW-1:0] fs_next(input logic [FS_PW-1:0] win);
      return (win == FS_PW'(NUM_IN_PORTS - 1)) ? '0 : win + FS_PW'(1);
   endfunction

   function automatic logic [OUT_PW-1:0] out_next(input logic [OUT_PW-1:0] win);
      return (win == OUT_PW'(NUM_OUT_PORTS - 1)) ? '0 : win + OUT_PW'(1);
   endfunction

   assign all_empty_s = &bus.i_empty;
   assign load_slot_s = (state_q == ST_IDLE) || bus.i_bft_ready;
   // Freespace wins unless its burst budget is spent while data is waiting.
   assign fs_sel_s    = (|bus.i_fs_req) &&
                        ((burst_q < BURST_W'(MAX_FS_BURST)) || all_empty_s);
   assign data_sel_s  = !fs_sel_s && !all_empty_s;
   assign fs_win_s    = fs_rr_pick(bus.i_fs_req, fs_ptr_q);
   assign out_win_s   = out_rr_pick(~bus.i_empty, out_ptr_q);

   // Next-state and registered-output computation for the load slot.
   always_comb begin
      state_d    = state_q;
      fs_ptr_d   = fs_ptr_q;
      out_ptr_d  = out_ptr_q;
      burst_d    = burst_q;
      stream_d   = stream_q;
      busy_d     = busy_q;
      fs_grant_d = '0;
      rd_en_d    = '0;
      if (load_slot_s) begin
         if (fs_sel_s) begin
            stream_d             = bus.i_fs_packet[int'(fs_win_s)*PACKET_BITS +: PACKET_BITS];
            fs_grant_d[fs_win_s] = 1'b1;
            fs_ptr_d             = fs_next(fs_win_s);
            state_d              = ST_HOLD;
            busy_d               = 1'b1;
            // Burst only counts while data is waiting behind freespace.
            if (all_empty_s) begin
               burst_d = '0;
            end else if (burst_q == BURST_W'(MAX_FS_BURST)) begin
               burst_d = burst_q;
            end else begin
               burst_d = burst_q + BURST_W'(1);
            end
         end else if (data_sel_s) begin
            stream_d            = bus.i_out_packet[int'(out_win_s)*PACKET_BITS +: PACKET_BITS];
            rd_en_d[out_win_s]  = 1'b1;
            out_ptr_d           = out_next(out_win_s);
            burst_d             = '0;
            state_d             = ST_HOLD;
            busy_d              = 1'b1;
         end else begin
            // Nothing to send (all FIFOs empty here): drop to idle.
            stream_d = '0;
            burst_d  = '0;
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, pointers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fs_ptr_q   <= '0;
         out_ptr_q  <= '0;
         burst_q    <= '0;
         stream_q   <= '0;
         fs_grant_q <= '0;
         rd_en_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fs_ptr_q   <= fs_ptr_d;
         out_ptr_q  <= out_ptr_d;
         burst_q    <= burst_d;
         stream_q   <= stream_d;
         fs_grant_q <= fs_grant_d;
         rd_en_q    <= rd_en_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.o_stream   = stream_q;
   assign bus.o_fs_grant = fs_grant_q;
   assign bus.o_rd_en    = rd_en_q;
   assign bus.o_busy     = busy_q;

`ifdef PACKET_ARBITER_STATS_EN
   logic [31:0] fs_count_q, data_count_q, stall_count_q;

   // Grant and stall statistics, free-running with natural wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fs_count_q    <= 32'd0;
         data_count_q  <= 32'd0;
         stall_count_q <= 32'd0;
      end else begin
         if (load_slot_s && fs_sel_s)   fs_count_q   <= fs_count_q + 32'd1;
         if (load_slot_s && data_sel_s) data_count_q <= data_count_q + 32'd1;
         if ((state_q == ST_HOLD) && !bus.i_bft_ready) stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign o_fs_count    = fs_count_q;
   assign o_data_count  = data_count_q;
   assign o_stall_count = stall_count_q;
`endif

endmodule
